// File: rtl/io_input_defs.sv
// rtl/io_input_defs.sv - shared state encodings, status field positions and defaults for the input port
package io_input_defs;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ACK     = 2'd2
    } read_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_CNT_W           = 19;

    localparam int NUM_SWITCHES = 4;
    localparam int NUM_BUTTONS  = 2;

    localparam int SW_LSB     = 0;
    localparam int BTN_LSB    = 4;
    localparam int STICKY_LSB = 6;
    localparam int COUNT_LSB  = 8;

    function automatic logic [15:0] pack_status(
        input logic [NUM_SWITCHES-1:0] sw,
        input logic [NUM_BUTTONS-1:0]  btn,
        input logic [NUM_BUTTONS-1:0]  sticky,
        input logic [7:0]              count
    );
        logic [15:0] word;
        word = '0;
        word[SW_LSB     +: NUM_SWITCHES] = sw;
        word[BTN_LSB    +: NUM_BUTTONS]  = btn;
        word[STICKY_LSB +: NUM_BUTTONS]  = sticky;
        word[COUNT_LSB  +: 8]            = count;
        return word;
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - two-flop synchroniser plus stability counter for one raw input
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // rise is registered so it lines up with the cycle stable first reads 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt    <= '0;
                stable <= sync2;
                rise   <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/io_input_port.sv
// rtl/io_input_port.sv - debounced switch/button status word returned to control via request/acknowledge
module io_input_port
    import io_input_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  switches,
    input  logic [1:0]  buttons,
    input  logic        InRead,
    output logic [15:0] InData,
    output logic        InAck,
    output logic [1:0]  btnPulse
);

    localparam int NUM_IN = NUM_SWITCHES + NUM_BUTTONS;

    logic [NUM_IN-1:0]      raw_all;
    logic [NUM_IN-1:0]      stable_all;
    logic [NUM_IN-1:0]      rise_all;
    logic [NUM_BUTTONS-1:0] btn_rise;
    logic [NUM_BUTTONS-1:0] sticky;
    logic [NUM_BUTTONS-1:0] sticky_clear;
    logic [7:0]             press_count;
    logic [15:0]            status;
    read_state_t            state;
    read_state_t            state_next;

    assign raw_all = {buttons, switches};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk   (CLK),
            .rst   (RESET),
            .raw   (raw_all[i]),
            .stable(stable_all[i]),
            .rise  (rise_all[i])
        );
    end

    // switch rise outputs are deliberately dropped: switches never raise events
    assign btn_rise = rise_all[NUM_IN-1:NUM_SWITCHES];
    assign btnPulse = btn_rise;

    assign status = pack_status(stable_all[NUM_SWITCHES-1:0],
                                stable_all[NUM_IN-1:NUM_SWITCHES],
                                sticky, press_count);

    // a press landing in the capture cycle survives the clear for the next read
    assign sticky_clear = (state == CAPTURE) ? sticky : '0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sticky      <= '0;
            press_count <= '0;
        end else begin
            sticky <= (sticky & ~sticky_clear) | btn_rise;
            if (btn_rise[0]) begin
                press_count <= press_count + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            InData <= '0;
        end else begin
            state <= state_next;
            if (state == CAPTURE) begin
                InData <= status;
            end
        end
    end

    always_comb begin
        state_next = state;
        InAck      = 1'b0;
        case (state)
            IDLE:    if (InRead) state_next = CAPTURE;
            CAPTURE: state_next = ACK;
            ACK: begin
                InAck      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
